axis_pkt_arbiter: RTL and testbench

// - Packet-granular round-robin arbiter: shares one AXI-Stream sink (the stream FIFO slave port) among NUM_SRC stream sources.
// - Sits between the stream producers and the FIFO; the register block drives enable/err_clr and reads the status outputs.
// - Once a source is granted it holds the output until the TLAST beat completes.
// - Enforces a maximum packet length.

---
 rtl/axis_pkt_arbiter.sv | 144 ++++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// axis_pkt_arbiter : packet-granular round-robin arbiter onto one AXI-Stream sink
// Rev 1.0 - initial release
// ============================================================================
module axis_pkt_arbiter #(
   parameter int NUM_SRC   = 2,
   parameter int WIDTH     = 32,
   parameter int MAX_BEATS = 256,
   parameter int IDXW      = $clog2(NUM_SRC)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     err_clr,
   input  logic [NUM_SRC-1:0]       s_axis_tvalid,
   input  logic [NUM_SRC*WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]       s_axis_tlast,
   output logic [NUM_SRC-1:0]       s_axis_tready,
   output logic                     m_axis_tvalid,
   output logic [WIDTH-1:0]         m_axis_tdata,
   output logic                     m_axis_tlast,
   input  logic                     m_axis_tready,
   output logic                     busy,
   output logic [IDXW-1:0]          grant_idx,
   output logic [31:0]              pkt_count,
   output logic                     trunc_err
);

   localparam int                C_CNTW      = $clog2(MAX_BEATS + 1);
   localparam logic [C_CNTW-1:0] C_LAST_BEAT = C_CNTW'(MAX_BEATS - 1);
   localparam logic [IDXW-1:0]   C_LAST_SRC  = IDXW'(NUM_SRC - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [IDXW-1:0]        r_rr_ptr;
   logic [IDXW-1:0]        r_grant_idx;
   logic [C_CNTW-1:0]      r_beat_cnt;
   logic [31:0]            r_pkt_count;
   logic                   r_trunc_err;

   logic [2*NUM_SRC-1:0]   w_rot_full;
   logic [NUM_SRC-1:0]     w_rot;
   logic [IDXW-1:0]        w_sel_idx;
   logic                   w_sel_found;
   logic                   w_grant_now;
   logic                   w_src_last;
   logic                   w_accept;
   logic                   w_pkt_end;
   logic                   w_trunc;

   // Rotate requests so bit 0 is the source at rr_ptr; lowest set bit wins.
   assign w_rot_full = {s_axis_tvalid, s_axis_tvalid} >> r_rr_ptr;
   assign w_rot      = w_rot_full[NUM_SRC-1:0];

   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = r_rr_ptr;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_sel_found = 1'b1;
            if (int'(r_rr_ptr) + k >= NUM_SRC)
               w_sel_idx = IDXW'(int'(r_rr_ptr) + k - NUM_SRC);
            else
               w_sel_idx = IDXW'(int'(r_rr_ptr) + k);
         end
      end
   end

   assign w_grant_now = (r_state == ST_IDLE) && enable && w_sel_found;

   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      w_src_last    = 1'b0;
      s_axis_tready = '0;
      if (r_state == ST_XFER) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant_idx == IDXW'(i)) begin
               m_axis_tvalid    = s_axis_tvalid[i];
               m_axis_tdata     = s_axis_tdata[i*WIDTH +: WIDTH];
               w_src_last       = s_axis_tlast[i];
               s_axis_tready[i] = m_axis_tready;
            end
         end
      end
   end

   // Forced tlast at the beat limit turns an over-long packet into two.
   assign m_axis_tlast = (r_state == ST_XFER) && (w_src_last || (r_beat_cnt == C_LAST_BEAT));
   assign w_accept     = m_axis_tvalid && m_axis_tready;
   assign w_pkt_end    = w_accept && m_axis_tlast;
   assign w_trunc      = w_pkt_end && !w_src_last;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_grant_now) w_state_nxt = ST_XFER;
         ST_XFER: if (w_pkt_end)   w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr    <= '0;
         r_grant_idx <= '0;
         r_beat_cnt  <= '0;
         r_pkt_count <= '0;
         r_trunc_err <= 1'b0;
      end else begin
         if (w_grant_now) begin
            r_grant_idx <= w_sel_idx;
            r_beat_cnt  <= '0;
         end else if (w_accept) begin
            r_beat_cnt  <= r_beat_cnt + 1'b1;
         end
         if (w_pkt_end) begin
            r_rr_ptr    <= (r_grant_idx == C_LAST_SRC) ? '0 : r_grant_idx + 1'b1;
            r_pkt_count <= r_pkt_count + 32'd1;
         end
         // A new truncation takes priority over a simultaneous clear.
         if (w_trunc)      r_trunc_err <= 1'b1;
         else if (err_clr) r_trunc_err <= 1'b0;
      end
   end

   assign busy      = (r_state == ST_XFER);
   assign grant_idx = r_grant_idx;
   assign pkt_count = r_pkt_count;
   assign trunc_err = r_trunc_err;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// tb_axis_pkt_arbiter : directed self-checking bench for axis_pkt_arbiter
// Rev 1.0 - initial release
// ============================================================================
module tb_axis_pkt_arbiter;

   typedef struct {
      logic [31:0] d;
      logic        l;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable, err_clr;
   logic [1:0]  s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [63:0] s_axis_tdata;
   logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        busy, trunc_err;
   logic [0:0]  grant_idx;
   logic [31:0] pkt_count;

   logic        t_enable, t_err_clr;
   logic [1:0]  t_s_axis_tvalid, t_s_axis_tlast, t_s_axis_tready;
   logic [63:0] t_s_axis_tdata;
   logic        t_m_axis_tvalid, t_m_axis_tlast, t_m_axis_tready;
   logic [31:0] t_m_axis_tdata;
   logic        t_busy, t_trunc_err;
   logic [0:0]  t_grant_idx;
   logic [31:0] t_pkt_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;
   bit bp_toggle;
   bit rdy0_seen;

   beat_t q0[$];
   beat_t q1[$];
   beat_t outq[$];
   int    ogq[$];
   int    ocyc[$];
   beat_t tq[$];
   beat_t toq[$];

   always #5 clk = ~clk;

   axis_pkt_arbiter #(.NUM_SRC(2), .WIDTH(32), .MAX_BEATS(256)) dut (
      .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .busy(busy), .grant_idx(grant_idx), .pkt_count(pkt_count), .trunc_err(trunc_err)
   );

   axis_pkt_arbiter #(.NUM_SRC(2), .WIDTH(32), .MAX_BEATS(4)) dut_t (
      .clk(clk), .rst(rst), .enable(t_enable), .err_clr(t_err_clr),
      .s_axis_tvalid(t_s_axis_tvalid), .s_axis_tdata(t_s_axis_tdata),
      .s_axis_tlast(t_s_axis_tlast), .s_axis_tready(t_s_axis_tready),
      .m_axis_tvalid(t_m_axis_tvalid), .m_axis_tdata(t_m_axis_tdata),
      .m_axis_tlast(t_m_axis_tlast), .m_axis_tready(t_m_axis_tready),
      .busy(t_busy), .grant_idx(t_grant_idx), .pkt_count(t_pkt_count), .trunc_err(t_trunc_err)
   );

   // Starts and ends at posedge+1; beats are logged only if the edge was not a reset edge.
   task automatic cycle();
      logic  hs0, hs1, hm;
      beat_t ob;
      int    og;
      s_axis_tvalid = {q1.size() > 0, q0.size() > 0};
      s_axis_tdata  = '0;
      s_axis_tlast  = '0;
      if (q0.size() > 0) begin s_axis_tdata[31:0]  = q0[0].d; s_axis_tlast[0] = q0[0].l; end
      if (q1.size() > 0) begin s_axis_tdata[63:32] = q1[0].d; s_axis_tlast[1] = q1[0].l; end
      m_axis_tready = bp_toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      hs0  = s_axis_tvalid[0] & s_axis_tready[0];
      hs1  = s_axis_tvalid[1] & s_axis_tready[1];
      hm   = m_axis_tvalid & m_axis_tready;
      ob.d = m_axis_tdata;
      ob.l = m_axis_tlast;
      og   = int'(grant_idx);
      if (s_axis_tready[0]) rdy0_seen = 1'b1;
      @(posedge clk);
      if (!rst) begin
         if (hm) begin outq.push_back(ob); ogq.push_back(og); ocyc.push_back(cyc); end
         if (hs0) void'(q0.pop_front());
         if (hs1) void'(q1.pop_front());
      end
      cyc++;
      #1;
   endtask

   task automatic t_cycle();
      logic  hm, hs;
      beat_t ob;
      t_s_axis_tvalid = {1'b0, tq.size() > 0};
      t_s_axis_tdata  = '0;
      t_s_axis_tlast  = '0;
      if (tq.size() > 0) begin t_s_axis_tdata[31:0] = tq[0].d; t_s_axis_tlast[0] = tq[0].l; end
      t_m_axis_tready = 1'b1;
      #1;
      hm   = t_m_axis_tvalid & t_m_axis_tready;
      hs   = t_s_axis_tvalid[0] & t_s_axis_tready[0];
      ob.d = t_m_axis_tdata;
      ob.l = t_m_axis_tlast;
      @(posedge clk);
      if (!rst) begin
         if (hm) toq.push_back(ob);
         if (hs) void'(tq.pop_front());
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      enable = 1'b1; err_clr = 1'b0; m_axis_tready = 1'b1;
      s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tlast = '0;
      t_enable = 1'b1; t_err_clr = 1'b0; t_m_axis_tready = 1'b1;
      t_s_axis_tvalid = '0; t_s_axis_tdata = '0; t_s_axis_tlast = '0;
      q0.delete(); q1.delete(); outq.delete(); ogq.delete(); ocyc.delete();
      tq.delete(); toq.delete();
      cyc = 0; bp_toggle = 1'b0; rdy0_seen = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk);
         #1;
         enable = 1'(($urandom)); err_clr = 1'($urandom); m_axis_tready = 1'($urandom);
         s_axis_tvalid = 2'($urandom); s_axis_tlast = 2'($urandom);
         s_axis_tdata = {$urandom, $urandom};
         #1;
         n_checks++;
         if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, grant_idx, trunc_err} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, grant_idx, trunc_err});
         end
         n_checks++;
         if (m_axis_tdata !== 32'h0 || pkt_count !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_data: tdata %h pkt_count %h expected 0", m_axis_tdata, pkt_count);
         end
      end
   endtask

   task automatic test_fairness();
      beat_t b;
      do_reset();
      for (int j = 0; j < 12; j++) begin
         b.l = (j % 3 == 2);
         b.d = 32'h100 + 32'(j); q0.push_back(b);
         b.d = 32'h200 + 32'(j); q1.push_back(b);
      end
      for (int n = 0; n < 80 && outq.size() < 12; n++) cycle();
      n_checks++;
      if (outq.size() < 12) begin
         n_errors++;
         $display("FAIL rr_timeout: got %0d beats expected 12", outq.size());
      end else begin
         n_checks++;
         if (pkt_count !== 32'd4) begin
            n_errors++;
            $display("FAIL rr_pkt_count: got %0d expected 4", pkt_count);
         end
         for (int j = 0; j < 12; j++) begin
            int    p   = j / 3;
            int    src = p % 2;
            logic [31:0] exp_d = (src == 1 ? 32'h200 : 32'h100) + 32'((p / 2) * 3 + j % 3);
            n_checks++;
            if (ogq[j] !== src || outq[j].d !== exp_d || outq[j].l !== (j % 3 == 2)) begin
               n_errors++;
               $display("FAIL rr_beat%0d: got grant %0d data %h last %b expected grant %0d data %h last %b",
                        j, ogq[j], outq[j].d, outq[j].l, src, exp_d, (j % 3 == 2));
            end
            if (j > 0) begin
               n_checks++;
               if (ocyc[j] - ocyc[j-1] !== ((j % 3 == 0) ? 2 : 1)) begin
                  n_errors++;
                  $display("FAIL rr_gap%0d: got %0d cycles expected %0d", j, ocyc[j] - ocyc[j-1], (j % 3 == 0) ? 2 : 1);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      beat_t b;
      do_reset();
      bp_toggle = 1'b1;
      for (int j = 0; j < 4; j++) begin
         b.d = 32'hA0 + 32'(j); b.l = (j == 3); q1.push_back(b);
      end
      for (int n = 0; n < 30 && outq.size() < 4; n++) cycle();
      repeat (3) cycle();
      n_checks++;
      if (outq.size() != 4) begin
         n_errors++;
         $display("FAIL bp_count: got %0d beats expected 4", outq.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (outq[j].d !== 32'hA0 + 32'(j) || outq[j].l !== (j == 3) || ogq[j] !== 1) begin
               n_errors++;
               $display("FAIL bp_beat%0d: got data %h last %b grant %0d expected data %h last %b grant 1",
                        j, outq[j].d, outq[j].l, ogq[j], 32'hA0 + 32'(j), (j == 3));
            end
         end
      end
      n_checks++;
      if (rdy0_seen !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_tready0: got %b expected 0", rdy0_seen);
      end
      n_checks++;
      if (pkt_count !== 32'd1) begin
         n_errors++;
         $display("FAIL bp_pkt_count: got %0d expected 1", pkt_count);
      end
   endtask

   task automatic test_truncation();
      beat_t b;
      bit    seen4 = 1'b0;
      do_reset();
      for (int j = 0; j < 6; j++) begin
         b.d = 32'h10 + 32'(j); b.l = (j == 5); tq.push_back(b);
      end
      for (int n = 0; n < 30 && toq.size() < 6; n++) begin
         // clear pulse coincides with the truncating beat: the set must win
         t_err_clr = (toq.size() == 3);
         t_cycle();
         if (toq.size() == 4 && !seen4) begin
            seen4 = 1'b1;
            n_checks++;
            if (t_trunc_err !== 1'b1) begin
               n_errors++;
               $display("FAIL trunc_set: got %b expected 1", t_trunc_err);
            end
         end
      end
      t_err_clr = 1'b0;
      n_checks++;
      if (toq.size() != 6) begin
         n_errors++;
         $display("FAIL trunc_count: got %0d beats expected 6", toq.size());
      end else begin
         for (int j = 0; j < 6; j++) begin
            n_checks++;
            if (toq[j].d !== 32'h10 + 32'(j) || toq[j].l !== (j == 3 || j == 5)) begin
               n_errors++;
               $display("FAIL trunc_beat%0d: got data %h last %b expected data %h last %b",
                        j, toq[j].d, toq[j].l, 32'h10 + 32'(j), (j == 3 || j == 5));
            end
         end
      end
      n_checks++;
      if (t_pkt_count !== 32'd2 || t_trunc_err !== 1'b1) begin
         n_errors++;
         $display("FAIL trunc_status: got pkt_count %0d trunc_err %b expected 2 and 1", t_pkt_count, t_trunc_err);
      end
      t_err_clr = 1'b1;
      t_cycle();
      t_err_clr = 1'b0;
      n_checks++;
      if (t_trunc_err !== 1'b0) begin
         n_errors++;
         $display("FAIL trunc_clr: got %b expected 0", t_trunc_err);
      end
   endtask

   task automatic test_enable_mid();
      beat_t b;
      bit    bad = 1'b0;
      do_reset();
      for (int j = 0; j < 8; j++) begin
         b.d = 32'h50 + 32'(j); b.l = (j == 7); q0.push_back(b);
      end
      for (int n = 0; n < 40 && outq.size() < 8; n++) begin
         cycle();
         if (outq.size() == 1) enable = 1'b0;
      end
      n_checks++;
      if (outq.size() != 8) begin
         n_errors++;
         $display("FAIL en_count: got %0d beats expected 8", outq.size());
      end else begin
         for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (outq[j].d !== 32'h50 + 32'(j) || outq[j].l !== (j == 7)) begin
               n_errors++;
               $display("FAIL en_beat%0d: got data %h last %b expected data %h last %b",
                        j, outq[j].d, outq[j].l, 32'h50 + 32'(j), (j == 7));
            end
         end
      end
      b.d = 32'h60; b.l = 1'b1; q0.push_back(b);
      b.d = 32'h70; q1.push_back(b);
      for (int n = 0; n < 10; n++) begin
         cycle();
         if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad || outq.size() != 8) begin
         n_errors++;
         $display("FAIL en_idle: got busy/valid seen %b beats %0d expected 0 and 8", bad, outq.size());
      end
   endtask

   task automatic test_reset_mid();
      beat_t b;
      do_reset();
      b.d = 32'h300; b.l = 1'b1; q0.push_back(b);
      b.d = 32'h310; b.l = 1'b0; q0.push_back(b);
      b.d = 32'h311; b.l = 1'b1; q0.push_back(b);
      for (int j = 0; j < 5; j++) begin
         b.d = 32'h400 + 32'(j); b.l = (j == 4); q1.push_back(b);
      end
      for (int n = 0; n < 30 && outq.size() < 3; n++) cycle();
      n_checks++;
      if (outq.size() != 3 || ogq[2] !== 1) begin
         n_errors++;
         $display("FAIL rm_setup: got %0d beats expected 3 with last grant 1", outq.size());
      end
      rst = 1'b1;
      cycle();
      n_checks++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || grant_idx !== 1'b0 || pkt_count !== 32'd0) begin
         n_errors++;
         $display("FAIL rm_state: got valid %b busy %b grant %0d pkt_count %0d expected all 0",
                  m_axis_tvalid, busy, grant_idx, pkt_count);
      end
      rst = 1'b0;
      for (int n = 0; n < 30 && outq.size() < 4; n++) cycle();
      n_checks++;
      if (outq.size() < 4) begin
         n_errors++;
         $display("FAIL rm_timeout: got %0d beats expected 4", outq.size());
      end else if (ogq[3] !== 0 || outq[3].d !== 32'h310) begin
         n_errors++;
         $display("FAIL rm_regrant: got grant %0d data %h expected grant 0 data 00000310", ogq[3], outq[3].d);
      end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_backpressure();
      test_truncation();
      test_enable_mid();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
